zic_arb_ctrl: RTL and testbench

Sequencing and arbitration engine of the Zilla interrupt controller. Latches 48 level interrupt sources into a pending vector and scans them serially, one source per cycle, against the per-source priority bytes and enable bits held in the MMR file. Posts the winning ID to the ACK register and raises the core interrupt line. Runs the claim/EOI handshake with the core and computes the next-pending ID for the NXTP register while an interrupt is active.

---
 rtl/zic_arb_ctrl_if.sv | 26 ++
 rtl/zic_arb_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_zic_arb_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zic_arb_ctrl_if.sv
// Core-facing handshake of the Zilla interrupt controller arbiter: claim/EOI from
// the core, interrupt line, and ACK/NXTP register write strobes toward the MMR file.
interface zic_arb_ctrl_if;
    logic       zic_irq_o;
    logic       zic_ack_i;
    logic       zic_eoi_valid_i;
    logic [7:0] zic_eoi_id_i;
    logic       zic_ack_write_valid_o;
    logic [7:0] zic_ack_int_id_o;
    logic       zic_nxtp_valid_o;
    logic [7:0] zic_nxtp_id_o;

    // Core / register-file side
    modport master (
        output zic_ack_i, zic_eoi_valid_i, zic_eoi_id_i,
        input  zic_irq_o, zic_ack_write_valid_o, zic_ack_int_id_o,
               zic_nxtp_valid_o, zic_nxtp_id_o
    );

    // Arbiter side
    modport slave (
        input  zic_ack_i, zic_eoi_valid_i, zic_eoi_id_i,
        output zic_irq_o, zic_ack_write_valid_o, zic_ack_int_id_o,
               zic_nxtp_valid_o, zic_nxtp_id_o
    );
endinterface

// File: rtl/zic_arb_ctrl.sv
// Zilla interrupt controller arbitration engine: latches 48 sources, scans one per
// cycle for the highest-priority eligible ID, runs claim/EOI and next-pending scans.
module zic_arb_ctrl (
    input  logic                 zic_clk,
    input  logic                 zic_rst,
    input  logic [47:0]          irq_src_i,
    input  logic [383:0]         irq_prio_i,
    input  logic [47:0]          zic_int_en_i,
    input  logic                 zic_global_en_i,
    zic_arb_ctrl_if.slave        core_if,
    output logic                 zic_int_pending_valid_o,
    output logic [47:0]          zic_int_pending_bit_o,
    output logic [7:0]           zic_active_id_o
);
    localparam int unsigned NUM_SRC  = 48;
    localparam logic [7:0]  ID_NONE  = 8'hFF;
    localparam logic [5:0]  LAST_IDX = 6'd47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESULT,
        ST_WAIT_CLAIM,
        ST_NXTP_RESULT,
        ST_ACTIVE
    } state_t;

    state_t      state_q;
    logic [5:0]  idx_q;
    logic        scan_nxtp_q;
    logic [7:0]  best_prio_q;
    logic [7:0]  best_id_q;
    logic [47:0] pending_q;
    logic [47:0] pending_d;
    logic        pend_valid_q;
    logic        irq_q;
    logic        ack_wr_q;
    logic [7:0]  ack_id_q;
    logic        nxtp_wr_q;
    logic [7:0]  nxtp_id_q;
    logic [7:0]  active_id_q;

    logic [7:0]  prio_arr [NUM_SRC];
    logic [47:0] prio_nz;
    logic [47:0] eligible;
    logic [47:0] clr_mask;

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_src
            assign prio_arr[gi] = irq_prio_i[8*gi +: 8];
            assign prio_nz[gi]  = |irq_prio_i[8*gi +: 8];
        end
    endgenerate

    assign eligible = pending_q & zic_int_en_i & {48{zic_global_en_i}} & prio_nz;

    // Candidate under the scan pointer and the scan result including it
    logic [7:0] cand_prio;
    logic [7:0] cand_id;
    logic       cand_take;
    logic [7:0] fin_id;
    logic       fin_ok;
    logic       claim;
    logic       eoi_hit;

    assign cand_prio = prio_arr[idx_q];
    assign cand_id   = {2'b00, idx_q};
    assign cand_take = eligible[idx_q] && (cand_id != active_id_q) && (cand_prio > best_prio_q);
    assign fin_id    = cand_take ? cand_id : best_id_q;
    // The winner is re-checked against live enables as the arbitrate scan closes
    assign fin_ok    = (fin_id != ID_NONE) && eligible[fin_id[5:0]];

    assign claim   = (state_q == ST_WAIT_CLAIM) && core_if.zic_ack_i;
    assign eoi_hit = core_if.zic_eoi_valid_i && (core_if.zic_eoi_id_i == active_id_q);

    always_comb begin
        clr_mask = '0;
        if (claim) begin
            clr_mask[best_id_q[5:0]] = 1'b1;
        end
    end

    // Clear beats a same-cycle set; a still-high source re-pends next cycle
    assign pending_d = (pending_q | irq_src_i) & ~clr_mask;

    always_ff @(posedge zic_clk) begin
        if (!zic_rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            scan_nxtp_q  <= 1'b0;
            best_prio_q  <= '0;
            best_id_q    <= ID_NONE;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            irq_q        <= 1'b0;
            ack_wr_q     <= 1'b0;
            ack_id_q     <= ID_NONE;
            nxtp_wr_q    <= 1'b0;
            nxtp_id_q    <= ID_NONE;
            active_id_q  <= ID_NONE;
        end else begin
            pending_q    <= pending_d;
            pend_valid_q <= (pending_d != pending_q);
            ack_wr_q     <= 1'b0;
            nxtp_wr_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        state_q     <= ST_SCAN;
                        idx_q       <= '0;
                        scan_nxtp_q <= 1'b0;
                        best_prio_q <= '0;
                        best_id_q   <= ID_NONE;
                    end
                end
                ST_SCAN: begin
                    if (scan_nxtp_q && eoi_hit) begin
                        state_q     <= ST_IDLE;
                        active_id_q <= ID_NONE;
                    end else begin
                        if (cand_take) begin
                            best_prio_q <= cand_prio;
                            best_id_q   <= cand_id;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (scan_nxtp_q) begin
                                state_q   <= ST_NXTP_RESULT;
                                nxtp_wr_q <= 1'b1;
                                nxtp_id_q <= fin_id;
                            end else if (fin_ok) begin
                                state_q  <= ST_RESULT;
                                ack_wr_q <= 1'b1;
                                ack_id_q <= fin_id;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                ST_RESULT: begin
                    state_q <= ST_WAIT_CLAIM;
                    irq_q   <= 1'b1;
                end
                ST_WAIT_CLAIM: begin
                    if (core_if.zic_ack_i) begin
                        irq_q       <= 1'b0;
                        active_id_q <= best_id_q;
                        state_q     <= ST_SCAN;
                        scan_nxtp_q <= 1'b1;
                        idx_q       <= '0;
                        best_prio_q <= '0;
                        best_id_q   <= ID_NONE;
                    end else if (!zic_global_en_i) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_NXTP_RESULT: begin
                    if (eoi_hit) begin
                        state_q     <= ST_IDLE;
                        active_id_q <= ID_NONE;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (eoi_hit) begin
                        state_q     <= ST_IDLE;
                        active_id_q <= ID_NONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_if.zic_irq_o             = irq_q;
    assign core_if.zic_ack_write_valid_o = ack_wr_q;
    assign core_if.zic_ack_int_id_o      = ack_id_q;
    assign core_if.zic_nxtp_valid_o      = nxtp_wr_q;
    assign core_if.zic_nxtp_id_o         = nxtp_id_q;
    assign zic_int_pending_valid_o       = pend_valid_q;
    assign zic_int_pending_bit_o         = pending_q;
    assign zic_active_id_o               = active_id_q;
endmodule

// File: tb/tb_zic_arb_ctrl.sv
// Directed bench for zic_arb_ctrl: a rule-level model checked every cycle, plus
// literal expectations on IDs and latencies for each scenario.
module tb_zic_arb_ctrl;
    logic         zic_clk;
    logic         zic_rst;
    logic [47:0]  irq_src;
    logic [383:0] irq_prio;
    logic [47:0]  zic_int_en;
    logic         zic_global_en;
    logic         pend_valid;
    logic [47:0]  pend_bits;
    logic [7:0]   active_id;

    zic_arb_ctrl_if bus ();

    zic_arb_ctrl dut (
        .zic_clk                 (zic_clk),
        .zic_rst                 (zic_rst),
        .irq_src_i               (irq_src),
        .irq_prio_i              (irq_prio),
        .zic_int_en_i            (zic_int_en),
        .zic_global_en_i         (zic_global_en),
        .core_if                 (bus),
        .zic_int_pending_valid_o (pend_valid),
        .zic_int_pending_bit_o   (pend_bits),
        .zic_active_id_o         (active_id)
    );

    int vectors = 0;
    int miscompares = 0;

    initial zic_clk = 1'b0;
    always #5 zic_clk = ~zic_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: controller behaviour in terms of rules ----------------
    localparam int PH_IDLE = 0, PH_SCAN = 1, PH_POSTED = 2, PH_WAITING = 3, PH_NXTP = 4, PH_SERVICE = 5;
    int          m_phase;
    int          m_left;
    bit          m_for_nxtp;
    logic [47:0] m_pend;
    logic        m_irq, m_ack_v, m_nx_v, m_pv;
    logic [7:0]  m_ack_id, m_nx_id, m_active;

    function automatic logic [47:0] eligible_now(input logic [47:0] pend);
        logic [47:0] e;
        for (int n = 0; n < 48; n++)
            e[n] = pend[n] && zic_int_en[n] && zic_global_en && (irq_prio[8*n +: 8] != 8'd0);
        return e;
    endfunction

    // Highest priority wins; among equals the lowest index
    function automatic logic [7:0] pick(input logic [47:0] elig, input logic [7:0] excl);
        int top;
        logic [7:0] w;
        top = 0;
        w = 8'hFF;
        for (int n = 0; n < 48; n++)
            if (elig[n] && n != int'(excl) && int'(irq_prio[8*n +: 8]) > top)
                top = int'(irq_prio[8*n +: 8]);
        for (int n = 47; n >= 0; n--)
            if (top != 0 && elig[n] && n != int'(excl) && int'(irq_prio[8*n +: 8]) == top)
                w = 8'(n);
        return w;
    endfunction

    task automatic model_step();
        logic [47:0] elig, clr, nxt;
        logic [7:0]  w;
        logic        eoi_hit;
        if (!zic_rst) begin
            m_phase = PH_IDLE; m_left = 0; m_for_nxtp = 0;
            m_pend = '0; m_irq = 0; m_ack_v = 0; m_nx_v = 0; m_pv = 0;
            m_ack_id = 8'hFF; m_nx_id = 8'hFF; m_active = 8'hFF;
        end else begin
            elig = eligible_now(m_pend);
            eoi_hit = bus.zic_eoi_valid_i && (bus.zic_eoi_id_i == m_active);
            clr = '0;
            m_ack_v = 0;
            m_nx_v = 0;
            case (m_phase)
                PH_IDLE: if (|elig) begin m_phase = PH_SCAN; m_left = 48; m_for_nxtp = 0; end
                PH_SCAN: begin
                    if (m_for_nxtp && eoi_hit) begin
                        m_phase = PH_IDLE; m_active = 8'hFF;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            w = pick(elig, m_active);
                            if (m_for_nxtp) begin
                                m_nx_v = 1; m_nx_id = w; m_phase = PH_NXTP;
                            end else if (w != 8'hFF) begin
                                m_ack_v = 1; m_ack_id = w; m_phase = PH_POSTED;
                            end else begin
                                m_phase = PH_IDLE;
                            end
                        end
                    end
                end
                PH_POSTED: begin m_phase = PH_WAITING; m_irq = 1; end
                PH_WAITING: begin
                    if (bus.zic_ack_i) begin
                        clr[m_ack_id[5:0]] = 1'b1;
                        m_active = m_ack_id; m_irq = 0;
                        m_phase = PH_SCAN; m_left = 48; m_for_nxtp = 1;
                    end else if (!zic_global_en) begin
                        m_irq = 0; m_phase = PH_IDLE;
                    end
                end
                PH_NXTP: begin
                    if (eoi_hit) begin m_phase = PH_IDLE; m_active = 8'hFF; end
                    else m_phase = PH_SERVICE;
                end
                default: if (eoi_hit) begin m_phase = PH_IDLE; m_active = 8'hFF; end
            endcase
            nxt = (m_pend | irq_src) & ~clr;
            m_pv = (nxt != m_pend);
            m_pend = nxt;
        end
    endtask

    always @(posedge zic_clk) begin
        model_step();
        #1;
        chk("irq", bus.zic_irq_o, m_irq);
        chk("ack_valid", bus.zic_ack_write_valid_o, m_ack_v);
        chk("ack_id", bus.zic_ack_int_id_o, m_ack_id);
        chk("nxtp_valid", bus.zic_nxtp_valid_o, m_nx_v);
        chk("nxtp_id", bus.zic_nxtp_id_o, m_nx_id);
        chk("pend_valid", pend_valid, m_pv);
        chk("pending", pend_bits, m_pend);
        chk("active_id", active_id, m_active);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge zic_clk);
    endtask

    task automatic do_reset();
        zic_rst = 1'b0;
        irq_src = '0; irq_prio = '0; zic_int_en = '0; zic_global_en = 1'b1;
        bus.zic_ack_i = 1'b0; bus.zic_eoi_valid_i = 1'b0; bus.zic_eoi_id_i = 8'h00;
        tick(3);
        zic_rst = 1'b1;
    endtask

    task automatic cfg(input int n, input int p, input bit en);
        irq_prio[8*n +: 8] = p[7:0];
        zic_int_en[n] = en;
    endtask

    task automatic pulse_src(input logic [47:0] bits);
        irq_src = bits;
        tick(1);
        irq_src = '0;
    endtask

    task automatic claim();
        bus.zic_ack_i = 1'b1;
        tick(1);
        bus.zic_ack_i = 1'b0;
    endtask

    task automatic eoi(input logic [7:0] id);
        bus.zic_eoi_valid_i = 1'b1;
        bus.zic_eoi_id_i = id;
        tick(1);
        bus.zic_eoi_valid_i = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output logic [7:0] id, output int cyc);
        cyc = 0;
        id = 8'hEE;
        while (cyc < budget && bus.zic_ack_write_valid_o !== 1'b1) begin tick(1); cyc++; end
        vectors++;
        if (bus.zic_ack_write_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_timeout: no ACK strobe within %0d cycles, expected one", budget);
        end else id = bus.zic_ack_int_id_o;
    endtask

    task automatic wait_nxtp(input int budget, output logic [7:0] id, output int cyc);
        cyc = 0;
        id = 8'hEE;
        while (cyc < budget && bus.zic_nxtp_valid_o !== 1'b1) begin tick(1); cyc++; end
        vectors++;
        if (bus.zic_nxtp_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL nxtp_timeout: no NXTP strobe within %0d cycles, expected one", budget);
        end else id = bus.zic_nxtp_id_o;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] id;
        int cyc;
        zic_rst = 1'b0;
        irq_src = '1; irq_prio = '0; zic_int_en = '0; zic_global_en = 1'b1;
        bus.zic_ack_i = 1'b0; bus.zic_eoi_valid_i = 1'b0; bus.zic_eoi_id_i = 8'h00;

        // Reset with every source high
        tick(3);
        chk("rst_pending", pend_bits, 48'h0);
        chk("rst_irq", bus.zic_irq_o, 1'b0);
        chk("rst_ack_id", bus.zic_ack_int_id_o, 8'hFF);
        chk("rst_active", active_id, 8'hFF);
        irq_src = '0;
        zic_rst = 1'b1;
        tick(2);
        $display("vec reset: pending=%0h irq=%0b", pend_bits, bus.zic_irq_o);

        // Single source 5, priority 10
        do_reset();
        cfg(5, 10, 1'b1);
        pulse_src(48'h1 << 5);
        chk("single_pend5", pend_bits[5], 1'b1);
        wait_ack(60, id, cyc);
        chk("single_ack_id", id, 8'd5);
        chk("single_ack_latency", cyc, 49);
        tick(1);
        chk("single_irq_high", bus.zic_irq_o, 1'b1);
        claim();
        chk("single_claim_irq", bus.zic_irq_o, 1'b0);
        chk("single_claim_pend5", pend_bits[5], 1'b0);
        chk("single_active", active_id, 8'd5);
        wait_nxtp(60, id, cyc);
        chk("single_nxtp_id", id, 8'hFF);
        chk("single_nxtp_latency", cyc, 48);
        tick(2);
        eoi(8'd5);
        chk("single_eoi_active", active_id, 8'hFF);
        $display("vec single: ack=5 nxtp=%0h active=%0h", id, active_id);

        // Priority and tie: 3/7, 20/9, 40/9
        do_reset();
        cfg(3, 7, 1'b1); cfg(20, 9, 1'b1); cfg(40, 9, 1'b1);
        pulse_src((48'h1 << 3) | (48'h1 << 20) | (48'h1 << 40));
        wait_ack(60, id, cyc);
        chk("prio_ack_id", id, 8'd20);
        tick(1);
        claim();
        wait_nxtp(60, id, cyc);
        chk("prio_nxtp_id", id, 8'd40);
        eoi(8'd20);   // lands in the NXTP result cycle
        chk("prio_eoi_active", active_id, 8'hFF);
        wait_ack(60, id, cyc);
        chk("prio_second_ack", id, 8'd40);
        chk("prio_second_latency", cyc, 49);
        tick(1);
        claim();
        wait_nxtp(60, id, cyc);
        chk("prio_second_nxtp", id, 8'd3);
        tick(1);
        eoi(8'd40);
        chk("prio_final_active", active_id, 8'hFF);
        $display("vec priority: acks 20,40 nxtp 40,3");

        // Masking by zero priority, then by enable
        do_reset();
        cfg(10, 0, 1'b1);
        pulse_src(48'h1 << 10);
        tick(60);
        chk("mask_prio0_irq", bus.zic_irq_o, 1'b0);
        chk("mask_pend10", pend_bits[10], 1'b1);
        cfg(10, 4, 1'b0);
        tick(60);
        chk("mask_en0_irq", bus.zic_irq_o, 1'b0);
        zic_int_en[10] = 1'b1;
        wait_ack(50, id, cyc);
        chk("mask_ack_id", id, 8'd10);
        chk("mask_ack_latency", cyc, 49);
        $display("vec masking: ack=%0d after %0d cycles", id, cyc);

        // Withdrawal: enable dropped mid-scan, then global disable while waiting
        do_reset();
        cfg(12, 5, 1'b1);
        pulse_src(48'h1 << 12);
        tick(20);
        zic_int_en[12] = 1'b0;
        tick(40);
        chk("wd_irq_low", bus.zic_irq_o, 1'b0);
        chk("wd_pend12", pend_bits[12], 1'b1);
        zic_int_en[12] = 1'b1;
        wait_ack(60, id, cyc);
        chk("wd_ack_id", id, 8'd12);
        tick(1);
        chk("wd_irq_high", bus.zic_irq_o, 1'b1);
        zic_global_en = 1'b0;
        tick(1);
        chk("wd_gdis_irq", bus.zic_irq_o, 1'b0);
        chk("wd_gdis_pend12", pend_bits[12], 1'b1);
        chk("wd_gdis_active", active_id, 8'hFF);
        zic_global_en = 1'b1;
        tick(3);
        $display("vec withdrawal: pending12=%0b", pend_bits[12]);

        // EOI rules and reset mid-scan
        do_reset();
        cfg(4, 3, 1'b1);
        pulse_src(48'h1 << 4);
        wait_ack(60, id, cyc);
        chk("eoi_ack_id", id, 8'd4);
        tick(1);
        claim();
        wait_nxtp(60, id, cyc);
        chk("eoi_nxtp_id", id, 8'hFF);
        tick(2);
        eoi(8'd9);
        chk("eoi_wrong_active", active_id, 8'd4);
        chk("eoi_wrong_irq", bus.zic_irq_o, 1'b0);
        tick(2);
        eoi(8'd4);
        chk("eoi_right_active", active_id, 8'hFF);
        pulse_src(48'h1 << 4);
        tick(10);
        zic_rst = 1'b0;
        tick(1);
        chk("midscan_rst_pending", pend_bits, 48'h0);
        chk("midscan_rst_ack_id", bus.zic_ack_int_id_o, 8'hFF);
        chk("midscan_rst_nxtp_id", bus.zic_nxtp_id_o, 8'hFF);
        chk("midscan_rst_active", active_id, 8'hFF);
        chk("midscan_rst_irq", bus.zic_irq_o, 1'b0);
        zic_rst = 1'b1;
        tick(60);
        chk("midscan_rst_quiet", bus.zic_irq_o, 1'b0);
        $display("vec eoi: active=%0h after mid-scan reset", active_id);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
